sdram_port_sched: RTL and testbench
===================================

Name: sdram_port_sched

Overview:
- Front-end scheduler that shares the SDRAM controller between one write stream and one read stream.
- The write stream is a write FIFO filled by the user side. The read stream is a read FIFO drained by the user side.
- Watches FIFO fill levels and issues burst write/read requests with linear addresses to the controller's write/read ports. Holds each request until the controller reports burst end.
- Manages address pointers with wrap inside programmable regions and round-robin fairness between the two ports.

Parameters:
- ADDR_W, 24, SDRAM linear word address width ({bank[1:0], row[12:0], col[8:0]}).
- CNT_W, 10, FIFO level counter width.
- BURST_LEN, 10'd256, words per burst, both ports.
- WR_BASE, 24'h000000, first address of write region.
- WR_LIMIT, 24'h000400, exclusive end of write region; (WR_LIMIT-WR_BASE) is a multiple of BURST_LEN.
- RD_BASE, 24'h000000, first address of read region.
- RD_LIMIT, 24'h000400, exclusive end of read region; (RD_LIMIT-RD_BASE) is a multiple of BURST_LEN.
- RD_THRESH, 10'd256, read burst issued while read FIFO level is below this.

Ports:
- clk, in, 1, system clock (SDRAM controller clock).
- rstn, in, 1, asynchronous active-low reset.
- init_done, in, 1, SDRAM initialisation complete (level, stays high).
- rd_enable, in, 1, level; read scheduling allowed while high.
- wr_fifo_cnt, in, CNT_W, words currently held in write FIFO.
- rd_fifo_cnt, in, CNT_W, words currently held in read FIFO.
- wr_ptr_clr, in, 1, one-cycle pulse; return write pointer to WR_BASE.
- rd_ptr_clr, in, 1, one-cycle pulse; return read pointer to RD_BASE.
- sdram_wr_req, out, 1, write burst request to controller.
- sdram_wr_addr, out, ADDR_W, start address of write burst.
- sdram_wr_end, in, 1, one-cycle pulse; write burst finished.
- sdram_rd_req, out, 1, read burst request to controller.
- sdram_rd_addr, out, ADDR_W, start address of read burst.
- sdram_rd_end, in, 1, one-cycle pulse; read burst finished.
- burst_len, out, CNT_W, constant BURST_LEN.
- busy, out, 1, high in WR_BUSY or RD_BUSY.

Behaviour:
- Reset (async, rstn low), all registered:
  - state = IDLE.
  - sdram_wr_req = 0, sdram_rd_req = 0, busy = 0.
  - wr_ptr = WR_BASE, rd_ptr = RD_BASE.
  - last_grant = READ, so the first tie goes to write.
  - Pending-clear flags = 0.
- Reset mid-burst aborts the burst silently; no completion is expected afterwards.
- sdram_wr_addr = wr_ptr and sdram_rd_addr = rd_ptr, driven from registers. Each address is stable for the whole time its request is high.
- Pending conditions:
  - wr_pend = (wr_fifo_cnt >= BURST_LEN).
  - rd_pend = rd_enable && (rd_fifo_cnt < RD_THRESH).
- States: IDLE, ARB, WR_BUSY, RD_BUSY.
- IDLE -> ARB when init_done = 1. No requests are issued in IDLE.
- ARB:
  - Only wr_pend -> WR_BUSY.
  - Only rd_pend -> RD_BUSY.
  - Both pending -> the port not equal to last_grant.
  - Neither pending -> stay in ARB.
  - On the transition, the corresponding req is set to 1 on the same clock edge (request visible 1 cycle after the pend condition is sampled). last_grant is updated.
- WR_BUSY:
  - sdram_wr_req held 1 until sdram_wr_end is sampled.
  - On that edge: req -> 0; wr_ptr += BURST_LEN; if the result >= WR_LIMIT, wr_ptr = WR_BASE; state -> ARB.
- RD_BUSY: same as WR_BUSY, using the rd signals and RD_BASE/RD_LIMIT.
- ARB is held for at least 1 cycle between bursts, so a new request cannot be issued on the edge that retires a burst (minimum 1 idle cycle with req low).
- Only one req is high at any time; never both.
- Pointer clear:
  - Clear pulse while the port is idle -> pointer = base on the next edge.
  - Clear pulse during that port's burst -> latched in a pending flag and applied at the end pulse instead of the increment.
  - Clear coinciding with the end pulse -> pointer = base (clear wins over increment).
- Spurious sdram_wr_end/sdram_rd_end while not in the matching BUSY state are ignored; no pointer change.
- rd_enable dropping during RD_BUSY does not cancel the burst in progress.
- init_done is not re-checked after leaving IDLE.
- Pointer arithmetic is ADDR_W bits, unsigned; overflow is impossible given the parameter constraints.

Test Plan:
1. Reset, init_done = 1 at cycle 5, wr_fifo_cnt = 256, rd_enable = 0 -> sdram_wr_req rises at cycle 7 with sdram_wr_addr = 0x000000. Pulse sdram_wr_end -> req low next cycle, wr_ptr = 0x000100.
2. Both ports pending continuously (wr_fifo_cnt = 300, rd_enable = 1, rd_fifo_cnt = 0), end pulse 10 cycles after each request -> grants alternate W,R,W,R. Addresses: W 0x000,0x100; R 0x000,0x100. Never both reqs high; ≥1 idle cycle between bursts.
3. Four write bursts with WR_LIMIT = 0x400 -> addresses 0x000, 0x100, 0x200, 0x300; fifth burst uses 0x000 (wrap).
4. wr_ptr_clr pulsed mid-WR_BUSY at address 0x200 -> that burst keeps address 0x200; next write burst uses 0x000. Repeat with clear on the same cycle as sdram_wr_end -> next write burst uses 0x000.
5. rd_fifo_cnt = 255 -> read request issued; rd_fifo_cnt = 256 -> none issued. rd_enable = 0 with rd_fifo_cnt = 0 -> none issued. Spurious sdram_rd_end in ARB -> rd_ptr unchanged.
6. rstn asserted low while sdram_rd_req = 1 -> all reqs low immediately (async). After release: state IDLE, pointers at base, no request until init_done is sampled high.

Source files
------------

// File: rtl/sdram_port_sched.sv
// sdram_port_sched: shares one SDRAM controller between a write stream and a
// read stream. It issues burst requests from FIFO fill levels, arbitrates
// round-robin on ties, and walks each port's address pointer through its own
// wrapping region.

// Per-port burst address pointer. It advances by one burst at the end of each
// burst and wraps to BASE at LIMIT. A clear that arrives mid-burst is held
// back so the address stays stable while the request is up.
module sdram_port_ptr #(
  parameter int                ADDR_W = 24,
  parameter logic [ADDR_W-1:0] BASE   = '0,
  parameter logic [ADDR_W-1:0] LIMIT  = 24'h000400,
  parameter logic [ADDR_W-1:0] STEP   = 24'h000100
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              active,  // this port owns the controller
  input  logic              done,    // burst-end pulse from controller
  input  logic              clr,     // pointer-clear pulse
  output logic [ADDR_W-1:0] ptr
);
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_inc;
  logic              clr_pend_q;

  assign ptr_inc = ptr_q + STEP;
  assign ptr     = ptr_q;

  // Pointer and deferred-clear flag. A clear always wins over the increment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q      <= BASE;
      clr_pend_q <= 1'b0;
    end else if (active && done) begin
      ptr_q      <= (clr || clr_pend_q || ptr_inc >= LIMIT) ? BASE : ptr_inc;
      clr_pend_q <= 1'b0;
    end else if (active) begin
      if (clr) clr_pend_q <= 1'b1;
    end else begin
      // Idle port: end pulses are ignored and a clear applies at once. A
      // clear on the grant edge lands together with the rising request, so
      // the address the controller sees is still stable.
      if (clr) ptr_q <= BASE;
      clr_pend_q <= 1'b0;
    end
  end
endmodule

module sdram_port_sched #(
  parameter int                ADDR_W    = 24,
  parameter int                CNT_W     = 10,
  parameter logic [CNT_W-1:0]  BURST_LEN = 10'd256,
  parameter logic [ADDR_W-1:0] WR_BASE   = 24'h000000,
  parameter logic [ADDR_W-1:0] WR_LIMIT  = 24'h000400,
  parameter logic [ADDR_W-1:0] RD_BASE   = 24'h000000,
  parameter logic [ADDR_W-1:0] RD_LIMIT  = 24'h000400,
  parameter logic [CNT_W-1:0]  RD_THRESH = 10'd256
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              init_done,
  input  logic              rd_enable,
  input  logic [CNT_W-1:0]  wr_fifo_cnt,
  input  logic [CNT_W-1:0]  rd_fifo_cnt,
  input  logic              wr_ptr_clr,
  input  logic              rd_ptr_clr,
  output logic              sdram_wr_req,
  output logic [ADDR_W-1:0] sdram_wr_addr,
  input  logic              sdram_wr_end,
  output logic              sdram_rd_req,
  output logic [ADDR_W-1:0] sdram_rd_addr,
  input  logic              sdram_rd_end,
  output logic [CNT_W-1:0]  burst_len,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ARB, WR_BUSY, RD_BUSY} state_t;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(BURST_LEN);

  state_t state_q, state_d;
  logic   last_rd_q, last_rd_d;  // 1: most recent grant went to the read port
  logic   wr_pend, rd_pend;
  logic   wr_req_q, rd_req_q, busy_q;

  assign wr_pend   = (wr_fifo_cnt >= BURST_LEN);
  assign rd_pend   = rd_enable && (rd_fifo_cnt < RD_THRESH);
  assign burst_len = BURST_LEN;

  // Next-state and grant selection. BUSY always returns through ARB, which
  // guarantees at least one low-request cycle between bursts.
  always_comb begin
    state_d   = state_q;
    last_rd_d = last_rd_q;
    case (state_q)
      IDLE: if (init_done) state_d = ARB;
      ARB: begin
        if (wr_pend && (!rd_pend || last_rd_q)) begin
          state_d   = WR_BUSY;
          last_rd_d = 1'b0;
        end else if (rd_pend) begin
          state_d   = RD_BUSY;
          last_rd_d = 1'b1;
        end
      end
      WR_BUSY: if (sdram_wr_end) state_d = ARB;
      RD_BUSY: if (sdram_rd_end) state_d = ARB;
      default: state_d = IDLE;
    endcase
  end

  // State register plus registered request/busy decoded from the next state,
  // so a request rises on the grant edge and drops on the end edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      last_rd_q <= 1'b1;
      wr_req_q  <= 1'b0;
      rd_req_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_rd_q <= last_rd_d;
      wr_req_q  <= (state_d == WR_BUSY);
      rd_req_q  <= (state_d == RD_BUSY);
      busy_q    <= (state_d == WR_BUSY) || (state_d == RD_BUSY);
    end
  end

  assign sdram_wr_req = wr_req_q;
  assign sdram_rd_req = rd_req_q;
  assign busy         = busy_q;

  sdram_port_ptr #(
    .ADDR_W(ADDR_W), .BASE(WR_BASE), .LIMIT(WR_LIMIT), .STEP(STEP)
  ) u_wr_ptr (
    .clk   (clk),
    .rstn  (rstn),
    .active(state_q == WR_BUSY),
    .done  (sdram_wr_end),
    .clr   (wr_ptr_clr),
    .ptr   (sdram_wr_addr)
  );

  sdram_port_ptr #(
    .ADDR_W(ADDR_W), .BASE(RD_BASE), .LIMIT(RD_LIMIT), .STEP(STEP)
  ) u_rd_ptr (
    .clk   (clk),
    .rstn  (rstn),
    .active(state_q == RD_BUSY),
    .done  (sdram_rd_end),
    .clr   (rd_ptr_clr),
    .ptr   (sdram_rd_addr)
  );
endmodule

// File: tb/tb_sdram_port_sched.sv
// Bench for sdram_port_sched: directed scenarios followed by a random phase,
// all checked every cycle against a burst-count reference model.
module tb_sdram_port_sched;
  localparam int AW = 24;
  localparam int CW = 10;
  localparam int BL = 256;
  localparam int WRB = 'h000, WRL = 'h400;
  localparam int RDB = 'h000, RDL = 'h400;
  localparam int TH = 256;

  logic          clk = 1'b0;
  logic          rstn, init_done, rd_enable, wr_ptr_clr, rd_ptr_clr;
  logic          wr_end, rd_end;
  logic [CW-1:0] wr_cnt, rd_cnt;
  logic          sdram_wr_req, sdram_rd_req, busy;
  logic [AW-1:0] sdram_wr_addr, sdram_rd_addr;
  logic [CW-1:0] burst_len;

  int checks = 0;
  int failures = 0;

  sdram_port_sched dut (
    .clk(clk), .rstn(rstn), .init_done(init_done), .rd_enable(rd_enable),
    .wr_fifo_cnt(wr_cnt), .rd_fifo_cnt(rd_cnt),
    .wr_ptr_clr(wr_ptr_clr), .rd_ptr_clr(rd_ptr_clr),
    .sdram_wr_req(sdram_wr_req), .sdram_wr_addr(sdram_wr_addr), .sdram_wr_end(wr_end),
    .sdram_rd_req(sdram_rd_req), .sdram_rd_addr(sdram_rd_addr), .sdram_rd_end(rd_end),
    .burst_len(burst_len), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the controller (0 none, 1 write, 2 read) and
  // how many bursts each port has completed since its last clear. Addresses
  // follow from the burst count modulo the region size.
  bit m_on;
  int m_own;
  bit m_pref_w;
  int m_wn, m_rn;
  bit m_wclr, m_rclr;

  function automatic void m_reset();
    m_on = 0; m_own = 0; m_pref_w = 1;
    m_wn = 0; m_rn = 0; m_wclr = 0; m_rclr = 0;
  endfunction

  function automatic void m_step();
    int own0 = m_own;
    bit wp = (int'(wr_cnt) >= BL);
    bit rp = rd_enable && (int'(rd_cnt) < TH);
    if (own0 == 1) begin
      if (wr_end) begin
        m_own = 0;
        if (wr_ptr_clr || m_wclr) m_wn = 0; else m_wn++;
        m_wclr = 0;
      end else if (wr_ptr_clr) m_wclr = 1;
    end else if (wr_ptr_clr) m_wn = 0;
    if (own0 == 2) begin
      if (rd_end) begin
        m_own = 0;
        if (rd_ptr_clr || m_rclr) m_rn = 0; else m_rn++;
        m_rclr = 0;
      end else if (rd_ptr_clr) m_rclr = 1;
    end else if (rd_ptr_clr) m_rn = 0;
    if (!m_on) begin
      if (init_done) m_on = 1;
    end else if (own0 == 0) begin
      if (wp && (!rp || m_pref_w)) begin m_own = 1; m_pref_w = 0; end
      else if (rp) begin m_own = 2; m_pref_w = 1; end
    end
  endfunction

  function automatic int exp_waddr(); return WRB + (m_wn * BL) % (WRL - WRB); endfunction
  function automatic int exp_raddr(); return RDB + (m_rn * BL) % (RDL - RDB); endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("wr_req", {31'b0, sdram_wr_req}, (m_own == 1) ? 1 : 0);
    chk("rd_req", {31'b0, sdram_rd_req}, (m_own == 2) ? 1 : 0);
    chk("busy", {31'b0, busy}, (m_own != 0) ? 1 : 0);
    chk("wr_addr", {8'b0, sdram_wr_addr}, exp_waddr());
    chk("rd_addr", {8'b0, sdram_rd_addr}, exp_raddr());
    chk("burst_len", {22'b0, burst_len}, BL);
    chk("both_req", {31'b0, sdram_wr_req & sdram_rd_req}, 0);
  endtask

  // One clock: model advances on the edge with the inputs the DUT sampled,
  // outputs are compared at the following falling edge.
  task automatic cycle();
    @(posedge clk);
    if (rstn) m_step(); else m_reset();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wait_own(input int who, input int max);
    int n = 0;
    while (m_own != who && n < max) begin cycle(); n++; end
    chk("grant_seen", {31'b0, (who == 1) ? sdram_wr_req : sdram_rd_req}, 1);
  endtask

  task automatic pulse_end(input bit w);
    if (w) wr_end = 1'b1; else rd_end = 1'b1;
    cycle();
    wr_end = 1'b0; rd_end = 1'b0;
  endtask

  task automatic reset_dut();
    rstn = 1'b0; init_done = 1'b0;
    #1 m_reset();
    repeat (2) cycle();
    rstn = 1'b1;
  endtask

  int exp_who [4] = '{1, 2, 1, 2};
  int exp_a2  [4] = '{'h000, 'h000, 'h100, 'h100};
  int exp_a3  [6] = '{'h000, 'h100, 'h200, 'h300, 'h000, 'h100};

  initial begin
    rstn = 1'b0; init_done = 1'b0; rd_enable = 1'b0;
    wr_cnt = '0; rd_cnt = '0; wr_ptr_clr = 1'b0; rd_ptr_clr = 1'b0;
    wr_end = 1'b0; rd_end = 1'b0;
    m_reset();

    // 1: reset state, first write burst timing and pointer step
    repeat (3) cycle();
    chk("rst_wr_req", {31'b0, sdram_wr_req}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    rstn = 1'b1;
    repeat (2) cycle();
    wr_cnt = 10'd256; init_done = 1'b1;
    cycle();
    chk("t1_no_req_yet", {31'b0, sdram_wr_req}, 0);
    cycle();
    chk("t1_req", {31'b0, sdram_wr_req}, 1);
    chk("t1_addr", {8'b0, sdram_wr_addr}, 'h000);
    repeat (3) cycle();
    wr_cnt = '0;
    pulse_end(1);
    chk("t1_req_drop", {31'b0, sdram_wr_req}, 0);
    chk("t1_ptr", {8'b0, sdram_wr_addr}, 'h100);

    // 2: both ports pending -> alternate W,R,W,R with an idle gap
    reset_dut();
    wr_cnt = 10'd300; rd_enable = 1'b1; rd_cnt = '0; init_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_own(exp_who[i], 20);
      if (exp_who[i] == 1) chk("t2_waddr", {8'b0, sdram_wr_addr}, exp_a2[i]);
      else                 chk("t2_raddr", {8'b0, sdram_rd_addr}, exp_a2[i]);
      repeat (9) cycle();
      pulse_end(exp_who[i] == 1);
      chk("t2_gap", {31'b0, sdram_wr_req | sdram_rd_req}, 0);
    end

    // 3: write region wrap
    reset_dut();
    rd_enable = 1'b0; wr_cnt = 10'd256; init_done = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_own(1, 20);
      chk("t3_waddr", {8'b0, sdram_wr_addr}, exp_a3[i]);
      repeat (2) cycle();
      pulse_end(1);
    end

    // 4: clear mid-burst is deferred; clear with end pulse wins
    wait_own(1, 20);
    chk("t4_addr_pre", {8'b0, sdram_wr_addr}, 'h200);
    cycle();
    wr_ptr_clr = 1'b1; cycle(); wr_ptr_clr = 1'b0;
    chk("t4_addr_hold", {8'b0, sdram_wr_addr}, 'h200);
    cycle();
    pulse_end(1);
    wait_own(1, 20);
    chk("t4_after_clr", {8'b0, sdram_wr_addr}, 'h000);
    cycle(); pulse_end(1);
    wait_own(1, 20);
    chk("t4_addr_100", {8'b0, sdram_wr_addr}, 'h100);
    cycle();
    wr_ptr_clr = 1'b1; pulse_end(1); wr_ptr_clr = 1'b0;
    wait_own(1, 20);
    chk("t4_clr_at_end", {8'b0, sdram_wr_addr}, 'h000);
    wr_cnt = '0;
    cycle(); pulse_end(1);

    // 5: read threshold boundary, rd_enable gating, spurious end pulses
    reset_dut();
    wr_cnt = '0; rd_enable = 1'b1; rd_cnt = 10'd255; init_done = 1'b1;
    wait_own(2, 20);
    chk("t5_raddr", {8'b0, sdram_rd_addr}, 'h000);
    rd_cnt = 10'd256;
    cycle(); pulse_end(0);
    repeat (10) cycle();
    chk("t5_at_thresh", {31'b0, sdram_rd_req}, 0);
    rd_cnt = '0; rd_enable = 1'b0;
    repeat (10) cycle();
    chk("t5_disabled", {31'b0, sdram_rd_req}, 0);
    pulse_end(0);
    chk("t5_spur_rd", {8'b0, sdram_rd_addr}, 'h100);
    pulse_end(1);
    chk("t5_spur_wr", {8'b0, sdram_wr_addr}, 'h000);

    // 6: async reset during a read burst
    rd_enable = 1'b1;
    wait_own(2, 20);
    chk("t6_raddr", {8'b0, sdram_rd_addr}, 'h100);
    cycle();
    #2 rstn = 1'b0;
    #1 m_reset();
    chk("t6_async_rd", {31'b0, sdram_rd_req}, 0);
    chk("t6_async_busy", {31'b0, busy}, 0);
    init_done = 1'b0;
    repeat (2) cycle();
    rstn = 1'b1;
    repeat (4) cycle();
    chk("t6_no_init", {31'b0, sdram_rd_req}, 0);
    chk("t6_rd_base", {8'b0, sdram_rd_addr}, 'h000);
    init_done = 1'b1;
    wait_own(2, 20);
    chk("t6_restart", {8'b0, sdram_rd_addr}, 'h000);

    // 7: random traffic against the model
    reset_dut();
    init_done = 1'b1;
    repeat (2000) begin
      wr_cnt     = CW'($urandom_range(0, 400));
      rd_cnt     = CW'($urandom_range(0, 400));
      rd_enable  = ($urandom_range(0, 3) != 0);
      wr_ptr_clr = ($urandom_range(0, 15) == 0);
      rd_ptr_clr = ($urandom_range(0, 15) == 0);
      wr_end     = !wr_end && ($urandom_range(0, 4) == 0);
      rd_end     = !rd_end && ($urandom_range(0, 4) == 0);
      cycle();
    end
    wr_end = 1'b0; rd_end = 1'b0; wr_ptr_clr = 1'b0; rd_ptr_clr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
